// File: rtl/vga_pattern_ctrl_if.sv
// Pixel-position, request and pixel-output bundle of the VGA pattern controller.
// master: the timing generator / control side; slave: the pattern controller.
interface vga_pattern_ctrl_if;
    logic [10:0] vga_xpos;
    logic [10:0] vga_ypos;
    logic        req_next;
    logic        req_prev;
    logic        auto_en;
    logic [1:0]  pattern_id;
    logic        sw_pending;
    logic [23:0] vga_data;

    modport master (
        output vga_xpos, vga_ypos, req_next, req_prev, auto_en,
        input  pattern_id, sw_pending, vga_data
    );

    modport slave (
        input  vga_xpos, vga_ypos, req_next, req_prev, auto_en,
        output pattern_id, sw_pending, vga_data
    );
endinterface

// File: rtl/vga_pattern_ctrl.sv
// VGA test-pattern generator: four patterns (colour bars H/V, checkerboard,
// grey ramp), switched only on entry to vertical blank, with optional timed
// auto-advance.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RUN   | no switch outstanding; auto-advance may step on a frame boundary
//   PEND  | a manual step (direction in dir_next) waits for the frame boundary
module vga_pattern_ctrl #(
    parameter int H_DISP      = 640,
    parameter int V_DISP      = 480,
    parameter int AUTO_FRAMES = 120
) (
    input logic              clk_25m,
    input logic              rst,
    vga_pattern_ctrl_if.slave bus
);
    localparam int          BAND_H    = V_DISP / 8;
    localparam int          BAND_W    = H_DISP / 8;
    localparam logic [10:0] H_LIM     = 11'(H_DISP);
    localparam logic [10:0] V_LIM     = 11'(V_DISP);
    localparam logic [10:0] V_LAST    = 11'(V_DISP - 1);
    localparam logic [7:0]  AUTO_LAST = 8'(AUTO_FRAMES - 1);

    typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

    state_t      state, state_d;
    logic        dir_next, dir_next_d;   // 1 = step forward, 0 = step back
    logic [1:0]  pat, pat_d;
    logic [7:0]  auto_cnt, auto_cnt_d;
    logic [10:0] ypos_prev;
    logic [23:0] pix, vga_data_q;
    logic [2:0]  band_v, band_h;
    logic        fb, req_valid;

    function automatic logic [23:0] band_colour(input logic [2:0] b);
        case (b)
            3'd0:    return 24'hff0000;
            3'd1:    return 24'h00ff00;
            3'd2:    return 24'h0000ff;
            3'd3:    return 24'hffffff;
            3'd4:    return 24'h000000;
            3'd5:    return 24'hffff00;
            3'd6:    return 24'hff00ff;
            default: return 24'h00ffff;
        endcase
    endfunction

    assign fb        = (bus.vga_ypos == V_LIM) && (ypos_prev == V_LAST);
    assign req_valid = bus.req_next ^ bus.req_prev;

    // Line history so the frame boundary fires once, on entry to vertical blank.
    always_ff @(posedge clk_25m) begin
        if (rst) ypos_prev <= '0;
        else     ypos_prev <= bus.vga_ypos;
    end

    // FSM state, latched direction, current pattern and auto-advance counter.
    always_ff @(posedge clk_25m) begin
        if (rst) begin
            state    <= RUN;
            dir_next <= 1'b1;
            pat      <= 2'd0;
            auto_cnt <= 8'd0;
        end else begin
            state    <= state_d;
            dir_next <= dir_next_d;
            pat      <= pat_d;
            auto_cnt <= auto_cnt_d;
        end
    end

    // Next-state: manual steps apply only at the frame boundary and beat auto-advance.
    always_comb begin
        state_d    = state;
        dir_next_d = dir_next;
        pat_d      = pat;
        auto_cnt_d = auto_cnt;
        case (state)
            RUN: begin
                if (fb && bus.auto_en) begin
                    if (auto_cnt == AUTO_LAST) begin
                        pat_d      = pat + 2'd1;
                        auto_cnt_d = 8'd0;
                    end else begin
                        auto_cnt_d = auto_cnt + 8'd1;
                    end
                end
                // A request in the boundary cycle itself waits for the next boundary.
                if (req_valid) begin
                    state_d    = PEND;
                    dir_next_d = bus.req_next;
                end
            end
            PEND: begin
                if (fb) begin
                    state_d    = RUN;
                    auto_cnt_d = 8'd0;
                    // A request arriving on the boundary itself still wins over the latched one.
                    if (req_valid ? bus.req_next : dir_next) pat_d = pat + 2'd1;
                    else                                     pat_d = pat - 2'd1;
                end else if (req_valid) begin
                    dir_next_d = bus.req_next;
                end
            end
            default: state_d = RUN;
        endcase
        if (!bus.auto_en) auto_cnt_d = 8'd0;
    end

    // Pixel colour for the current position; bands clamp to 7 past the last full band.
    always_comb begin
        band_v = 3'd0;
        band_h = 3'd0;
        pix    = 24'h000000;
        for (int k = 1; k < 8; k++) begin
            if ({21'd0, bus.vga_ypos} >= 32'(k * BAND_H)) band_v = 3'(k);
            if ({21'd0, bus.vga_xpos} >= 32'(k * BAND_W)) band_h = 3'(k);
        end
        if (bus.vga_xpos < H_LIM && bus.vga_ypos < V_LIM) begin
            case (pat)
                2'd0:    pix = band_colour(band_v);
                2'd1:    pix = band_colour(band_h);
                2'd2:    pix = {24{bus.vga_xpos[5] ^ bus.vga_ypos[5]}};
                default: pix = {3{bus.vga_xpos[9:2]}};
            endcase
        end
    end

    // One-cycle registered pixel output.
    always_ff @(posedge clk_25m) begin
        if (rst) vga_data_q <= 24'h000000;
        else     vga_data_q <= pix;
    end

    assign bus.pattern_id = pat;
    assign bus.sw_pending = (state == PEND);
    assign bus.vga_data   = vga_data_q;
endmodule

// File: tb/tb_vga_pattern_ctrl.sv
// Scoreboard bench for vga_pattern_ctrl: a driver issues pixel positions and
// requests while a reference model pushes the expected outputs; a monitor pops
// and compares after every clock edge.
module tb_vga_pattern_ctrl;
    localparam int H  = 640;
    localparam int V  = 480;
    localparam int AF = 2;

    typedef struct {
        logic [23:0] pix;
        logic [1:0]  pat;
        logic        pend;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    vga_pattern_ctrl_if bus();

    vga_pattern_ctrl #(.H_DISP(H), .V_DISP(V), .AUTO_FRAMES(AF)) dut (
        .clk_25m (clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #20 clk = ~clk;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // reference model state
    int m_pat   = 0;
    bit m_pend  = 0;
    bit m_dir   = 1;
    int m_cnt   = 0;
    int m_yprev = 0;

    bit ae   = 0;
    bit r_in = 1;

    logic [23:0] colours [8] = '{24'hff0000, 24'h00ff00, 24'h0000ff, 24'hffffff,
                                24'h000000, 24'hffff00, 24'hff00ff, 24'h00ffff};

    function automatic logic [23:0] ref_pix(int pat, int x, int y);
        int b, g;
        if (x >= H || y >= V) return 24'h000000;
        case (pat)
            0: begin b = y / (V / 8); if (b > 7) b = 7; return colours[b]; end
            1: begin b = x / (H / 8); if (b > 7) b = 7; return colours[b]; end
            2: return ((((x / 32) + (y / 32)) % 2) == 1) ? 24'hffffff : 24'h000000;
            default: begin g = (x / 4) % 256; return 24'(g * 65793); end
        endcase
    endfunction

    task automatic cyc(input int x, input int y, input bit rn, input bit rp);
        exp_t e;
        bit   fb, valid;
        @(negedge clk);
        rst          = r_in;
        bus.vga_xpos = 11'(x);
        bus.vga_ypos = 11'(y);
        bus.req_next = rn;
        bus.req_prev = rp;
        bus.auto_en  = ae;
        if (r_in) begin
            m_pat = 0; m_pend = 0; m_cnt = 0; m_yprev = 0;
            e.pix = 24'h000000;
        end else begin
            e.pix = ref_pix(m_pat, x, y);
            fb    = (y == V) && (m_yprev == V - 1);
            valid = (rn != rp);
            if (fb && m_pend) begin
                m_pat  = (m_pat + ((valid ? rn : m_dir) ? 1 : 3)) % 4;
                m_pend = 0;
                m_cnt  = 0;
            end else begin
                if (fb && ae) begin
                    if (m_cnt == AF - 1) begin m_pat = (m_pat + 1) % 4; m_cnt = 0; end
                    else m_cnt++;
                end
                if (valid) begin m_pend = 1; m_dir = rn; end
            end
            if (!ae) m_cnt = 0;
            m_yprev = y;
        end
        e.pat  = 2'(m_pat);
        e.pend = m_pend;
        q.push_back(e);
    endtask

    task automatic frame_end();
        cyc($urandom_range(0, 799), V - 1, 0, 0);
        cyc($urandom_range(0, 799), V, 0, 0);
    endtask

    task automatic lines(input int n);
        for (int i = 0; i < n; i++) cyc($urandom_range(0, 799), $urandom_range(0, V - 2), 0, 0);
    endtask

    // Monitor: compare every DUT output against the queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if (bus.vga_data === e.pix) n_pass++;
            else $display("FAIL vga_data @%0t: got %h expected %h", $time, bus.vga_data, e.pix);
            n_checks++;
            if (bus.pattern_id === e.pat) n_pass++;
            else $display("FAIL pattern_id @%0t: got %0d expected %0d", $time, bus.pattern_id, e.pat);
            n_checks++;
            if (bus.sw_pending === e.pend) n_pass++;
            else $display("FAIL sw_pending @%0t: got %0b expected %0b", $time, bus.sw_pending, e.pend);
        end
    end

    initial begin
        bus.vga_xpos = '0; bus.vga_ypos = '0;
        bus.req_next = 0;  bus.req_prev = 0; bus.auto_en = 0;

        // reset, with a request and a frame boundary held under it
        r_in = 1;
        cyc(0, 0, 1, 0);
        cyc(10, V - 1, 1, 0);
        cyc(10, V, 0, 1);
        r_in = 0;

        // pattern 0 pixels and the blanking edges
        cyc(100, 60, 0, 0);
        cyc(100, 479, 0, 0);
        cyc(640, 60, 0, 0);
        cyc(639, 0, 0, 0);
        cyc(0, 479, 0, 0);
        cyc(5, 100, 0, 0);
        lines(20);

        // next requested mid-frame, applied on entry to vertical blank
        cyc(10, 200, 1, 0);
        lines(5);
        frame_end();
        cyc(85, 10, 0, 0);
        lines(20);

        // two prev steps: 1 -> 0 -> 3
        cyc(3, 50, 0, 1); lines(3); frame_end(); lines(20);
        cyc(3, 50, 0, 1); lines(3); frame_end(); lines(20);

        // next, prev, next inside one frame: single step 3 -> 0
        cyc(1, 10, 1, 0); lines(2);
        cyc(1, 20, 0, 1); lines(2);
        cyc(1, 30, 1, 0); lines(2);
        frame_end(); lines(10);

        // both requests together are ignored
        cyc(1, 40, 1, 1); lines(2); frame_end(); lines(10);

        // request in the boundary cycle while in RUN waits a frame
        cyc(7, V - 1, 0, 0);
        cyc(7, V, 1, 0);
        lines(5); frame_end(); lines(10);

        // request in the boundary cycle while pending overrides the direction
        cyc(7, 30, 0, 1); lines(3);
        cyc(7, V - 1, 0, 0);
        cyc(7, V, 1, 0);
        lines(10);

        // auto-advance every second boundary, then a manual next mid-interval
        ae = 1;
        for (int i = 0; i < 8; i++) begin lines(4); frame_end(); end
        lines(3); frame_end();
        cyc(9, 100, 1, 0); lines(3); frame_end();
        for (int i = 0; i < 4; i++) begin lines(4); frame_end(); end
        ae = 0;
        lines(5);

        // reset while a switch is pending
        cyc(9, 100, 1, 0); lines(3);
        r_in = 1; cyc(9, 120, 0, 0); r_in = 0;
        lines(3); frame_end(); lines(3); frame_end(); lines(10);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel, y;
            r_in = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 149) == 0) ae = ~ae;
            sel = $urandom_range(0, 9);
            y   = (sel == 0) ? V - 1 : (sel == 1) ? V : $urandom_range(0, 524);
            cyc($urandom_range(0, 799), y,
                $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);
        end
        r_in = 0;

        repeat (3) @(negedge clk);
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vga_pattern_ctrl.md
VGA_PATTERN_CTRL -- requirements
Module: vga_pattern_ctrl

Interface
REQ-001 Parameter H_DISP, default 640: active pixels per line.
REQ-002 Parameter V_DISP, default 480: active lines per frame.
REQ-003 Parameter AUTO_FRAMES, default 120: frames per pattern in auto mode; legal range 1..255.
REQ-004 clk_25m  input  1  pixel clock; one clock domain, all logic rising-edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 vga_xpos  input  11  current pixel column from the timing generator.
REQ-007 vga_ypos  input  11  current line from the timing generator.
REQ-008 req_next  input  1  single-cycle request to advance the pattern (already debounced).
REQ-009 req_prev  input  1  single-cycle request to step back one pattern.
REQ-010 auto_en  input  1  level; high enables timed auto-advance.
REQ-011 pattern_id  output  2  pattern currently displayed.
REQ-012 sw_pending  output  1  high while a switch request waits for the frame boundary.
REQ-013 vga_data  output  24  RGB888 pixel, {R,G,B}.

Function
REQ-014 Active region is vga_xpos < H_DISP and vga_ypos < V_DISP; outside it, vga_data SHALL be 24'h000000.
REQ-015 vga_data SHALL be registered: the value for (xpos,ypos) sampled at edge N appears after edge N (1-cycle latency).
REQ-016 Pattern 0: eight horizontal bands of V_DISP/8 lines, top to bottom: ff0000, 00ff00, 0000ff, ffffff, 000000, ffff00, ff00ff, 00ffff. Lines at or beyond 7*(V_DISP/8) use band 7.
REQ-017 Pattern 1: the same eight colours, as vertical bands of H_DISP/8 columns, left to right. Columns at or beyond 7*(H_DISP/8) use band 7.
REQ-018 Pattern 2: 32x32 checkerboard. Output ffffff when xpos[5]^ypos[5] is 1, else 000000.
REQ-019 Pattern 3: grey ramp. Each of R, G and B equals xpos[9:2].
REQ-020 Frame boundary (fb) is a one-cycle internal pulse. It fires when vga_ypos == V_DISP and the registered previous ypos == V_DISP-1, i.e. on entry to vertical blank.
REQ-021 The FSM has two states. RUN is the reset state. PEND means a request is latched.
REQ-022 RUN -> PEND on a valid request; the direction is latched.
REQ-023 PEND -> RUN on fb. On that same edge, pattern_id updates.
REQ-024 A valid request is req_next xor req_prev. If both are high in the same cycle, the request is ignored.
REQ-025 In PEND, a new valid request overwrites the latched direction; the switch still happens at the next fb.
REQ-026 A valid request in the fb cycle while in RUN goes to PEND and applies at the following fb.
REQ-027 A valid request in the fb cycle while in PEND applies the new direction on that fb.
REQ-028 Next wraps 3 -> 0; prev wraps 0 -> 3.
REQ-029 sw_pending SHALL be 1 exactly while in PEND.
REQ-030 Auto counter is 8 bits. When auto_en is high it increments on each fb.
REQ-031 When the counter is AUTO_FRAMES-1 at an fb, that fb performs next (in RUN), and the counter clears to 0.
REQ-032 At an fb in PEND, the pending direction takes priority over auto-advance. Only one step occurs, and the counter clears.
REQ-033 Any applied manual switch clears the counter.
REQ-034 auto_en low holds the counter at 0.

Reset
REQ-035 On rst, at a clock edge: pattern_id = 0, FSM = RUN, sw_pending = 0, auto counter = 0, ypos history = 0, vga_data = 24'h000000.
REQ-036 rst asserted in PEND discards the pending request; no switch occurs after reset is released.
REQ-037 rst has priority over every simultaneous request or fb.

Verification
REQ-038 Pattern 0 active, xpos=100, ypos=60 -> vga_data 00ff00 one cycle later; ypos=479 -> 00ffff; xpos=640 -> 000000.
REQ-039 req_next pulse at line 200 -> sw_pending=1 until ypos 479->480; pattern_id 0->1 on that edge; xpos=85, ypos=10 -> 00ff00.
REQ-040 From pattern_id=0, req_prev -> 3 at next fb; then req_next, req_prev, req_next within one frame -> single step to 0; both requests high together -> no change.
REQ-041 AUTO_FRAMES=2, auto_en=1, no requests -> pattern_id steps 0,1,2,3,0 at every second fb; a manual next mid-interval resets the count.
REQ-042 rst pulse while sw_pending=1 -> all outputs reset, pattern_id stays 0 through the next two fbs.
